// File: rtl/jt7759_feeder_pkg.sv
// Shared widths and small helpers for the jt7759 ROM-to-chip byte feeder.
package jt7759_feeder_pkg;

  localparam int ADDR_W = 17;  // ROM byte address width
  localparam int DATA_W = 8;   // ROM / chip data width
  localparam int WCNT_W = 4;   // strobe-width counter, holds up to 15 ticks

  // Next ROM address; the natural 17-bit wrap takes 0x1FFFF back to 0x00000.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/jt7759_feeder.sv
// Streams a block of ROM bytes into a jt7759-style sample chip.
// Each byte is fetched from ROM, then held until the chip asks for data with a
// falling edge on drqn, then written with a cs/wrn strobe WR_CYC cen ticks wide.
//
// Handshakes:
//   rom side : rom_cs is held high while fetching; the byte on rom_data is
//              taken in the cycle rom_ok is high, after which rom_cs drops.
//   chip side: each drqn falling edge seen while busy grants exactly one
//              write; a level held low never grants a second one.
//   control  : start is a one-cycle request honoured only when idle; stop
//              aborts from FETCH/READY at once, and from WRITE only after the
//              strobe in flight has finished. done pulses once per transfer.
module jt7759_feeder
  import jt7759_feeder_pkg::*;
#(
  parameter int WR_CYC = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cen,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_ok,
  input  logic              drqn,
  output logic              cs,
  output logic              wrn,
  output logic [DATA_W-1:0] dout,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_READY = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [WCNT_W-1:0] WR_LAST = WCNT_W'(WR_CYC - 1);

  state_t              state, state_nxt;
  logic                drqn_l;
  logic                pending, pending_nxt;
  logic                stop_l, stop_l_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   dout_r, dout_nxt;
  logic [WCNT_W-1:0]   wr_cnt, wr_cnt_nxt;
  logic                drq_fall;
  logic                in_busy;
  logic                nxt_busy;

  assign drq_fall  = ~drqn & drqn_l;
  assign in_busy   = (state == ST_FETCH) || (state == ST_READY) || (state == ST_WRITE);
  assign nxt_busy  = (state_nxt == ST_FETCH) || (state_nxt == ST_READY) ||
                     (state_nxt == ST_WRITE);
  assign state_dbg = state;
  assign rom_addr  = addr;
  assign dout      = dout_r;

  // Next-state and datapath updates for the transfer sequencer.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    stop_l_nxt  = stop_l;
    addr_nxt    = addr;
    cnt_nxt     = cnt;
    dout_nxt    = dout_r;
    wr_cnt_nxt  = wr_cnt;

    // A chip request arriving while busy is remembered until READY uses it.
    if (in_busy && drq_fall) begin
      pending_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        // Requests seen while idle belong to no transfer and are dropped.
        pending_nxt = 1'b0;
        stop_l_nxt  = 1'b0;
        if (start) begin
          if (len != '0) begin
            addr_nxt  = start_addr;
            cnt_nxt   = len;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end

      ST_FETCH: begin
        if (stop) begin
          state_nxt = ST_DONE;
        end else if (rom_ok) begin
          dout_nxt  = rom_data;
          state_nxt = ST_READY;
        end
      end

      ST_READY: begin
        if (stop) begin
          state_nxt = ST_DONE;
        end else if (pending || drq_fall) begin
          pending_nxt = 1'b0;
          wr_cnt_nxt  = '0;
          state_nxt   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // An abort here only takes effect once the strobe is complete.
        if (stop) begin
          stop_l_nxt = 1'b1;
        end
        if (cen) begin
          if (wr_cnt == WR_LAST) begin
            addr_nxt = addr_inc(addr);
            cnt_nxt  = cnt - {{(ADDR_W-1){1'b0}}, 1'b1};
            if ((cnt_nxt == '0) || stop_l || stop) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_FETCH;
            end
          end else begin
            wr_cnt_nxt = wr_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      ST_DONE: begin
        pending_nxt = 1'b0;
        stop_l_nxt  = 1'b0;
        state_nxt   = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and datapath; reset clears everything immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      drqn_l  <= 1'b1;
      pending <= 1'b0;
      stop_l  <= 1'b0;
      addr    <= '0;
      cnt     <= '0;
      dout_r  <= '0;
      wr_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      drqn_l  <= drqn;
      pending <= pending_nxt;
      stop_l  <= stop_l_nxt;
      addr    <= addr_nxt;
      cnt     <= cnt_nxt;
      dout_r  <= dout_nxt;
      wr_cnt  <= wr_cnt_nxt;
    end
  end

  // Glitch-free registered outputs decoded from the state being entered, so
  // they line up exactly with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs     <= 1'b0;
      wrn    <= 1'b1;
      rom_cs <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      cs     <= (state_nxt == ST_WRITE);
      wrn    <= (state_nxt != ST_WRITE);
      rom_cs <= (state_nxt == ST_FETCH);
      busy   <= nxt_busy;
      done   <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_jt7759_feeder.sv
// Bench for jt7759_feeder: a ROM responder with programmable latency, a
// strobe monitor, and one task per scenario checked against a byte-list model.
module tb_jt7759_feeder;

  localparam int WR_CYC = 4;

  logic        clk;
  logic        rstn;
  logic        cen;
  logic        start;
  logic [16:0] start_addr;
  logic [16:0] len;
  logic        stop;
  logic        busy;
  logic        done;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        drqn;
  logic        cs;
  logic        wrn;
  logic [7:0]  dout;
  logic [2:0]  state_dbg;

  jt7759_feeder #(.WR_CYC(WR_CYC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cen        (cen),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .drqn       (drqn),
    .cs         (cs),
    .wrn        (wrn),
    .dout       (dout),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // ---------------- ROM contents model ----------------
  function automatic logic [7:0] rom_fn(input logic [16:0] a);
    logic [7:0] b;
    b = (a[7:0] + 8'h3C) ^ {a[11:8], a[15:12]} ^ (a[16] ? 8'hA5 : 8'h00);
    return b;
  endfunction

  // ---------------- ROM responder ----------------
  int rom_delay = 0;
  int dly_cnt = 0;
  initial begin
    rom_ok = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rom_ok) begin
        rom_ok = 1'b0;
        dly_cnt = 0;
      end else if (rom_cs) begin
        if (dly_cnt >= rom_delay) begin
          rom_data = rom_fn(rom_addr);
          rom_ok = 1'b1;
          dly_cnt = 0;
        end else begin
          dly_cnt++;
        end
      end else begin
        dly_cnt = 0;
      end
    end
  end

  // ---------------- cen driver ----------------
  bit cen_rand = 1'b0;
  initial begin
    cen = 1'b1;
    forever begin
      @(negedge clk);
      cen = cen_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  // ---------------- strobe monitor ----------------
  logic [7:0] got_b[$];
  int         got_t[$];
  int         got_w[$];
  int         wrn_bad, dout_bad, done_cnt;
  bit         busy_seen, rom_cs_seen;
  logic       prev_cs = 1'b0;
  logic [7:0] cur_byte;
  int         cur_t, cur_w;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cs === 1'b1) begin
        if (prev_cs !== 1'b1) begin
          cur_byte = dout;
          cur_t = 0;
          cur_w = 0;
        end else if (dout !== cur_byte) begin
          dout_bad++;
        end
        cur_w++;
        if (cen) cur_t++;
      end else if (prev_cs === 1'b1) begin
        got_b.push_back(cur_byte);
        got_t.push_back(cur_t);
        got_w.push_back(cur_w);
      end
      if (wrn !== ~cs) wrn_bad++;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (rom_cs === 1'b1) rom_cs_seen = 1'b1;
      prev_cs = cs;
    end
  end

  // ---------------- expected model ----------------
  logic [7:0] exp_q[$];

  task automatic build_exp(input logic [16:0] a, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(rom_fn(17'((int'(a) + i) % 131072)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_b.delete();
    got_t.delete();
    got_w.delete();
    wrn_bad = 0;
    dout_bad = 0;
    done_cnt = 0;
    busy_seen = 1'b0;
    rom_cs_seen = 1'b0;
  endtask

  task automatic do_start(input logic [16:0] a, input logic [16:0] n, input bit with_stop);
    @(negedge clk);
    start_addr = a;
    len = n;
    start = 1'b1;
    stop = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic drq_edge();
    @(negedge clk);
    drqn = 1'b1;
    @(negedge clk);
    drqn = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Keeps requesting bytes until the transfer ends or the budget runs out.
  task automatic drive_edges(input int gmin, input int gmax, output bit to);
    int n;
    int g;
    n = 0;
    while (busy && n < 4000) begin
      g = $urandom_range(gmin, gmax);
      tick(g);
      drq_edge();
      n += g + 2;
    end
    to = busy;
    tick(4);
  endtask

  task automatic wait_idle(input int max, output bit to);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    to = busy;
    tick(4);
  endtask

  task automatic wait_cs(input int max, output bit to);
    int n;
    n = 0;
    while (cs !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    to = (cs !== 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b0; stop = 1'b0; drqn = 1'b1;
    start_addr = '0; len = '0;
    tick(3);
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", cs); end
    checks++; if (wrn !== 1'b1) begin errors++; $display("FAIL reset_wrn got=%b exp=1", wrn); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs got=%b exp=0", rom_cs); end
    checks++; if (rom_addr !== 17'h0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    bit to;
    cen_rand = 1'b0; rom_delay = 1;
    clear_mon();
    build_exp(17'h00100, 3);
    do_start(17'h00100, 17'd3, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    drive_edges(40, 40, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout busy=%b exp=0", busy); end
    checks++; if (got_b.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      checks++; if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got_b[i], exp_q[i]); end
      checks++; if (got_w[i] != WR_CYC) begin errors++; $display("FAIL basic_width%0d got=%0d exp=%0d", i, got_w[i], WR_CYC); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    checks++; if (wrn_bad != 0 || dout_bad != 0) begin errors++; $display("FAIL basic_strobe_shape wrn_bad=%0d dout_bad=%0d exp=0", wrn_bad, dout_bad); end
  endtask

  task automatic test_zero_len();
    cen_rand = 1'b0; rom_delay = 0;
    clear_mon();
    do_start(17'h00500, 17'd0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_now got=%b exp=1", done); end
    tick(4);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy got=1 exp=0"); end
    checks++; if (rom_cs_seen) begin errors++; $display("FAIL zero_rom_cs got=1 exp=0"); end
    checks++; if (got_b.size() != 0) begin errors++; $display("FAIL zero_strobes got=%0d exp=0", got_b.size()); end
  endtask

  task automatic test_wrap();
    bit to;
    cen_rand = 1'b0; rom_delay = 2;
    clear_mon();
    build_exp(17'h1FFFF, 2);
    do_start(17'h1FFFF, 17'd2, 1'b0);
    drive_edges(8, 20, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout busy=%b exp=0", busy); end
    checks++; if (got_b.size() != 2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", got_b.size()); end
    for (int i = 0; i < 2 && i < got_b.size(); i++) begin
      checks++; if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_late_rom();
    bit to;
    int n;
    cen_rand = 1'b0; rom_delay = 10;
    clear_mon();
    do_start(17'h00200, 17'd2, 1'b0);
    tick(2);
    checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL late_rom_cs got=%b exp=1", rom_cs); end
    drq_edge();
    n = 0;
    while (got_b.size() < 1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (got_b.size() != 1) begin errors++; $display("FAIL late_first_strobe got=%0d exp=1", got_b.size()); end
    else begin
      checks++; if (got_b[0] !== rom_fn(17'h00200)) begin errors++; $display("FAIL late_byte got=%h exp=%h", got_b[0], rom_fn(17'h00200)); end
    end
    tick(100);
    checks++; if (got_b.size() != 1) begin errors++; $display("FAIL late_held_low got=%0d exp=1", got_b.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL late_still_busy got=%b exp=1", busy); end
    pulse_stop();
    wait_idle(20, to);
    checks++; if (to || done_cnt != 1) begin errors++; $display("FAIL late_stop_done busy=%b done_cnt=%0d exp=0/1", busy, done_cnt); end
    rom_delay = 0;
  endtask

  task automatic test_stop_write();
    bit to;
    cen_rand = 1'b0; rom_delay = 0;
    clear_mon();
    do_start(17'h00300, 17'd5, 1'b0);
    tick(3);
    drq_edge();
    wait_cs(20, to);
    checks++; if (to) begin errors++; $display("FAIL stopw_no_strobe cs=%b exp=1", cs); end
    pulse_stop();
    wait_idle(40, to);
    checks++; if (to) begin errors++; $display("FAIL stopw_timeout busy=%b exp=0", busy); end
    checks++; if (got_b.size() != 1) begin errors++; $display("FAIL stopw_count got=%0d exp=1", got_b.size()); end
    else begin
      checks++; if (got_w[0] != WR_CYC) begin errors++; $display("FAIL stopw_width got=%0d exp=%0d", got_w[0], WR_CYC); end
      checks++; if (got_b[0] !== rom_fn(17'h00300)) begin errors++; $display("FAIL stopw_byte got=%h exp=%h", got_b[0], rom_fn(17'h00300)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stopw_done got=%0d exp=1", done_cnt); end
    clear_mon();
    for (int i = 0; i < 3; i++) begin tick(10); drq_edge(); end
    tick(10);
    checks++; if (got_b.size() != 0 || busy_seen) begin errors++; $display("FAIL stopw_after strobes=%0d busy_seen=%b exp=0/0", got_b.size(), busy_seen); end
  endtask

  task automatic test_start_stop_together();
    bit to;
    cen_rand = 1'b0; rom_delay = 0;
    clear_mon();
    do_start(17'h00400, 17'd1, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL startstop_busy got=%b exp=1", busy); end
    drive_edges(5, 10, to);
    checks++; if (to || got_b.size() != 1) begin errors++; $display("FAIL startstop_xfer strobes=%0d exp=1", got_b.size()); end
  endtask

  task automatic test_start_while_busy();
    bit to;
    cen_rand = 1'b0; rom_delay = 1;
    clear_mon();
    build_exp(17'h00A00, 2);
    do_start(17'h00A00, 17'd2, 1'b0);
    tick(2);
    do_start(17'h00F00, 17'd7, 1'b0);
    drive_edges(6, 12, to);
    checks++; if (to) begin errors++; $display("FAIL busystart_timeout busy=%b exp=0", busy); end
    checks++; if (got_b.size() != 2) begin errors++; $display("FAIL busystart_count got=%0d exp=2", got_b.size()); end
    for (int i = 0; i < 2 && i < got_b.size(); i++) begin
      checks++; if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL busystart_byte%0d got=%h exp=%h", i, got_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_idle_edge();
    bit to;
    cen_rand = 1'b0; rom_delay = 0;
    clear_mon();
    drq_edge();
    tick(2);
    do_start(17'h00600, 17'd1, 1'b0);
    tick(15);
    checks++; if (got_b.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL idle_edge strobes=%0d busy=%b exp=0/1", got_b.size(), busy); end
    drive_edges(3, 6, to);
    checks++; if (to || got_b.size() != 1) begin errors++; $display("FAIL idle_edge_after strobes=%0d exp=1", got_b.size()); end
    else begin
      checks++; if (got_b[0] !== rom_fn(17'h00600)) begin errors++; $display("FAIL idle_edge_byte got=%h exp=%h", got_b[0], rom_fn(17'h00600)); end
    end
  endtask

  task automatic test_reset_write();
    bit to;
    cen_rand = 1'b0; rom_delay = 0;
    clear_mon();
    do_start(17'h00700, 17'd3, 1'b0);
    tick(3);
    drq_edge();
    wait_cs(20, to);
    checks++; if (to) begin errors++; $display("FAIL rstw_no_strobe cs=%b exp=1", cs); end
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (cs !== 1'b0 || wrn !== 1'b1) begin errors++; $display("FAIL rstw_async cs=%b wrn=%b exp=0/1", cs, wrn); end
    checks++; if (busy !== 1'b0 || rom_addr !== 17'h0) begin errors++; $display("FAIL rstw_state busy=%b rom_addr=%h exp=0/0", busy, rom_addr); end
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
    clear_mon();
    build_exp(17'h00800, 2);
    do_start(17'h00800, 17'd2, 1'b0);
    drive_edges(6, 12, to);
    checks++; if (to || got_b.size() != 2) begin errors++; $display("FAIL rstw_restart strobes=%0d exp=2", got_b.size()); end
    for (int i = 0; i < 2 && i < got_b.size(); i++) begin
      checks++; if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL rstw_byte%0d got=%h exp=%h", i, got_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [16:0] a;
    int n;
    cen_rand = 1'b1;
    for (int t = 0; t < 6; t++) begin
      a = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 131071)) : 17'(131072 - $urandom_range(1, 3));
      n = $urandom_range(1, 4);
      rom_delay = $urandom_range(0, 5);
      clear_mon();
      build_exp(a, n);
      do_start(a, 17'(n), 1'b0);
      drive_edges(10, 30, to);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout busy=%b exp=0", t, busy); end
      checks++; if (got_b.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, got_b.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
        checks++; if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", t, i, got_b[i], exp_q[i]); end
        checks++; if (got_t[i] != WR_CYC) begin errors++; $display("FAIL rand%0d_ticks%0d got=%0d exp=%0d", t, i, got_t[i], WR_CYC); end
      end
      checks++; if (done_cnt != 1 || wrn_bad != 0 || dout_bad != 0) begin errors++; $display("FAIL rand%0d_misc done=%0d wrn_bad=%0d dout_bad=%0d exp=1/0/0", t, done_cnt, wrn_bad, dout_bad); end
    end
    cen_rand = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_late_rom();
    test_stop_write();
    test_start_stop_together();
    test_start_while_busy();
    test_idle_edge();
    test_reset_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
